// File: rtl/tone_pkg.sv
// -----------------------------------------------------------------------------
// tone_pkg
// Shared constants for the note/tone path (also used by rtttl_sequencer):
//   - note index constants NOTE_C .. NOTE_B (0..11)
//   - bus widths NOTE_W (one-hot note) and OCT_W (octave)
//   - REST encoding of the note bus
//   - half_period_lut(): octave-0 half-period in 1 MHz ticks per note index
// -----------------------------------------------------------------------------
package tone_pkg;

    localparam int NOTE_W = 16;
    localparam int OCT_W  = 4;

    localparam logic [3:0] NOTE_C  = 4'd0;
    localparam logic [3:0] NOTE_CS = 4'd1;
    localparam logic [3:0] NOTE_D  = 4'd2;
    localparam logic [3:0] NOTE_DS = 4'd3;
    localparam logic [3:0] NOTE_E  = 4'd4;
    localparam logic [3:0] NOTE_F  = 4'd5;
    localparam logic [3:0] NOTE_FS = 4'd6;
    localparam logic [3:0] NOTE_G  = 4'd7;
    localparam logic [3:0] NOTE_GS = 4'd8;
    localparam logic [3:0] NOTE_A  = 4'd9;
    localparam logic [3:0] NOTE_AS = 4'd10;
    localparam logic [3:0] NOTE_B  = 4'd11;

    localparam logic [NOTE_W-1:0] REST = 16'h0000;

    // Octave-0 half-period in ticks; unused indices return 0 so they read as silent.
    function automatic logic [15:0] half_period_lut(input logic [3:0] idx);
        logic [15:0] half;
        case (idx)
            NOTE_C:  half = 16'd30577;
            NOTE_CS: half = 16'd28862;
            NOTE_D:  half = 16'd27242;
            NOTE_DS: half = 16'd25714;
            NOTE_E:  half = 16'd24269;
            NOTE_F:  half = 16'd22907;
            NOTE_FS: half = 16'd21622;
            NOTE_G:  half = 16'd20408;
            NOTE_GS: half = 16'd19263;
            NOTE_A:  half = 16'd18182;
            NOTE_AS: half = 16'd17161;
            NOTE_B:  half = 16'd16198;
            default: half = 16'd0;
        endcase
        return half;
    endfunction

endpackage

// File: rtl/onehot_note_decode.sv
// -----------------------------------------------------------------------------
// onehot_note_decode
// Combinational decode of the one-hot note bus.
// Ports:
//   note  in  [NOTE_W-1:0]  one-hot note (bits 0..11 notes, 12..15 reserved)
//   idx   out [3:0]         index of the set note bit (meaningful when valid)
//   valid out 1             exactly one of bits 0..11 set and bits 12..15 clear
// -----------------------------------------------------------------------------
module onehot_note_decode
    import tone_pkg::*;
(
    input  logic [NOTE_W-1:0] note,
    output logic [3:0]        idx,
    output logic              valid
);

    logic [3:0] count_s;
    logic [3:0] idx_s;

    // Population count and index of the (last) set bit among the 12 note bits.
    always_comb begin
        count_s = 4'd0;
        idx_s   = 4'd0;
        for (int i = 0; i < 12; i++) begin
            if (note[i]) begin
                count_s = count_s + 4'd1;
                idx_s   = 4'(i);
            end else begin
                count_s = count_s;
            end
        end
    end

    assign idx   = idx_s;
    assign valid = (count_s == 4'd1) && (note[15:12] == 4'b0000);

endmodule

// File: rtl/tone_generator.sv
// -----------------------------------------------------------------------------
// tone_generator
// Square-wave tone generator fed by rtttl_sequencer. The octave-0 half-period
// of the selected note is shifted right by the octave and the output toggles
// every half-period of prescaled ticks.
// Parameters:
//   CLK_DIV    tick prescaler (>= 1); counter advances once every CLK_DIV clocks
//   MAX_OCTAVE highest octave that plays; higher octaves are silent
// Ports:
//   clk    in  1            system clock (nominal 1 MHz)
//   rstn   in  1            asynchronous active-low reset
//   octave in  [OCT_W-1:0]  octave from the sequencer
//   note   in  [NOTE_W-1:0] one-hot note, all-zero = rest
//   spk    out 1            square-wave output
//   active out 1            high while a valid tone is sounding
//   spk_n  out 1            (only with TONE_GEN_COMPLEMENT_EN) complement of
//                           spk while active, 0 while silent
// Configuration macro: TONE_GEN_COMPLEMENT_EN
// -----------------------------------------------------------------------------
module tone_generator
    import tone_pkg::*;
#(
    parameter int CLK_DIV    = 1,
    parameter int MAX_OCTAVE = 8
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic [OCT_W-1:0]  octave,
    input  logic [NOTE_W-1:0] note,
    output logic              spk,
    output logic              active
`ifdef TONE_GEN_COMPLEMENT_EN
    ,
    output logic              spk_n
`endif
);

    localparam int PW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [PW-1:0] PRESC_LAST = PW'(CLK_DIV - 1);

    logic [NOTE_W-1:0] note_q_r;
    logic [OCT_W-1:0]  octave_q_r;
    logic [3:0]        idx_r;
    logic [15:0]       counter_r;
    logic [PW-1:0]     presc_r;
    logic              spk_r;
    logic              active_r;

    logic [3:0]        in_idx_s;
    logic              in_onehot_s;
    logic [15:0]       in_half_s;
    logic              in_valid_s;
    logic [15:0]       half_s;
    logic              change_s;
    logic              tick_s;

    logic [15:0]       counter_nx_s;
    logic [PW-1:0]     presc_nx_s;
    logic              spk_nx_s;
    logic              active_nx_s;

    onehot_note_decode u_decode (
        .note  (note),
        .idx   (in_idx_s),
        .valid (in_onehot_s)
    );

    // Validity is judged on the incoming value so it can be registered in the
    // same edge that captures it; active_r therefore always describes note_q_r.
    assign in_half_s  = half_period_lut(in_idx_s) >> octave;
    assign in_valid_s = in_onehot_s
                        && (int'({28'd0, octave}) <= MAX_OCTAVE)
                        && (in_half_s != 16'd0);

    assign half_s   = half_period_lut(idx_r) >> octave_q_r;
    assign change_s = ({note, octave} != {note_q_r, octave_q_r});
    assign tick_s   = (presc_r == PRESC_LAST);

    // Next-state: restart on change, hold cleared while silent, else count ticks.
    always_comb begin
        counter_nx_s = counter_r;
        presc_nx_s   = presc_r;
        spk_nx_s     = spk_r;
        active_nx_s  = active_r;
        if (change_s) begin
            counter_nx_s = 16'd0;
            presc_nx_s   = '0;
            spk_nx_s     = 1'b0;
            active_nx_s  = in_valid_s;
        end else if (!active_r) begin
            counter_nx_s = 16'd0;
            presc_nx_s   = '0;
            spk_nx_s     = 1'b0;
            active_nx_s  = 1'b0;
        end else if (tick_s) begin
            presc_nx_s = '0;
            if (counter_r == (half_s - 16'd1)) begin
                counter_nx_s = 16'd0;
                spk_nx_s     = ~spk_r;
            end else begin
                counter_nx_s = counter_r + 16'd1;
            end
        end else begin
            presc_nx_s = presc_r + PW'(1);
        end
    end

    // Input capture and tone state registers.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            note_q_r   <= 16'h0000;
            octave_q_r <= 4'd0;
            idx_r      <= 4'd0;
            counter_r  <= 16'd0;
            presc_r    <= '0;
            spk_r      <= 1'b0;
            active_r   <= 1'b0;
        end else begin
            note_q_r   <= note;
            octave_q_r <= octave;
            idx_r      <= in_idx_s;
            counter_r  <= counter_nx_s;
            presc_r    <= presc_nx_s;
            spk_r      <= spk_nx_s;
            active_r   <= active_nx_s;
        end
    end

    assign spk    = spk_r;
    assign active = active_r;

`ifdef TONE_GEN_COMPLEMENT_EN
    logic spk_n_r;

    // Bridge-tied complement output, forced low whenever the tone is silent.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            spk_n_r <= 1'b0;
        end else begin
            spk_n_r <= active_nx_s & ~spk_nx_s;
        end
    end

    assign spk_n = spk_n_r;
`endif

endmodule

// File: tb/tb_tone_generator.sv
module tb_tone_generator;

    logic        clk = 1'b0;
    logic        rstn;
    logic [3:0]  octave;
    logic [15:0] note;
    logic        spk1, active1, spk4, active4;
`ifdef TONE_GEN_COMPLEMENT_EN
    logic        spk_n1, spk_n4;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    tone_generator #(.CLK_DIV(1), .MAX_OCTAVE(8)) dut1 (
        .clk(clk), .rstn(rstn), .octave(octave), .note(note),
        .spk(spk1), .active(active1)
`ifdef TONE_GEN_COMPLEMENT_EN
        , .spk_n(spk_n1)
`endif
    );

    tone_generator #(.CLK_DIV(4), .MAX_OCTAVE(8)) dut4 (
        .clk(clk), .rstn(rstn), .octave(octave), .note(note),
        .spk(spk4), .active(active4)
`ifdef TONE_GEN_COMPLEMENT_EN
        , .spk_n(spk_n4)
`endif
    );

    // ---------------- reference model ----------------
    localparam int TBL [12] = '{30577, 28862, 27242, 25714, 24269, 22907,
                                21622, 20408, 19263, 18182, 17161, 16198};

    function automatic int ref_half(input logic [15:0] n, input logic [3:0] o);
        int h;
        h = 0;
        for (int i = 0; i < 12; i++)
            if (n[i]) h = TBL[i] >> o;
        return h;
    endfunction

    function automatic bit ref_valid(input logic [15:0] n, input logic [3:0] o);
        return ($countones(n[11:0]) == 1) && (n[15:12] == 4'd0)
               && (o <= 4'd8) && (ref_half(n, o) != 0);
    endfunction

    int          cyc = 0;
    int          m_start = 0;
    int          m_half = 0;
    bit          m_valid = 1'b0;
    logic [15:0] m_note = 16'h0000;
    logic [3:0]  m_oct = 4'd0;

    always @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            m_note  <= 16'h0000;
            m_oct   <= 4'd0;
            m_valid <= 1'b0;
        end else begin
            cyc <= cyc + 1;
            if ({note, octave} != {m_note, m_oct}) begin
                m_note  <= note;
                m_oct   <= octave;
                m_valid <= ref_valid(note, octave);
                m_half  <= ref_half(note, octave);
                m_start <= cyc + 1;
            end
        end
    end

    // Output is high during odd-numbered half-periods since the restart.
    function automatic logic exp_spk(input int d);
        int t;
        if (!m_valid) return 1'b0;
        t = cyc - m_start;
        return ((t / (m_half * d)) % 2) == 1;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Cycle-by-cycle comparison of both instances against the model.
    always @(negedge clk) begin
        chk("model_spk_div1",    {31'd0, spk1},    {31'd0, exp_spk(1)});
        chk("model_active_div1", {31'd0, active1}, {31'd0, m_valid});
        chk("model_spk_div4",    {31'd0, spk4},    {31'd0, exp_spk(4)});
        chk("model_active_div4", {31'd0, active4}, {31'd0, m_valid});
`ifdef TONE_GEN_COMPLEMENT_EN
        chk("model_spk_n_div1", {31'd0, spk_n1}, {31'd0, m_valid & ~exp_spk(1)});
        chk("model_spk_n_div4", {31'd0, spk_n4}, {31'd0, m_valid & ~exp_spk(4)});
`endif
    end

    // ---------------- directed vectors ----------------
    typedef struct {
        logic [15:0] note;
        logic [3:0]  oct;
        logic        act;
        int          half;
        int          hold;
    } vec_t;

    vec_t tbl [9];

    initial begin
        tbl[0] = '{16'h0200, 4'd4, 1'b1, 1136,  6816};   // A4, switch lands in high phase
        tbl[1] = '{16'h0800, 4'd4, 1'b1, 1012,  2500};   // B4
        tbl[2] = '{16'h0001, 4'd0, 1'b1, 30577, 100};    // C0
        tbl[3] = '{16'h0001, 4'd8, 1'b1, 119,   500};    // C8
        tbl[4] = '{16'h0000, 4'd4, 1'b0, 0,     2500};   // rest
        tbl[5] = '{16'h0003, 4'd4, 1'b0, 0,     2500};   // multi-hot
        tbl[6] = '{16'h1000, 4'd4, 1'b0, 0,     2500};   // reserved bit
        tbl[7] = '{16'h0200, 4'd9, 1'b0, 0,     2500};   // octave too high
        tbl[8] = '{16'h0200, 4'd4, 1'b1, 1136,  12000};  // A4, div4 toggles twice

        rstn   = 1'b0;
        note   = 16'h0000;
        octave = 4'd0;
        repeat (3) @(negedge clk);
        chk("reset_spk",    {31'd0, spk1},    32'd0);
        chk("reset_active", {31'd0, active1}, 32'd0);
        rstn = 1'b1;
        @(negedge clk);

        for (int v = 0; v < 9; v++) begin
            note   = tbl[v].note;
            octave = tbl[v].oct;
            @(negedge clk);
            chk("restart_active", {31'd0, active1}, {31'd0, tbl[v].act});
            chk("restart_spk",    {31'd0, spk1},    32'd0);
            if (tbl[v].act) begin
                repeat (tbl[v].half - 1) @(negedge clk);
                chk("pre_edge_low", {31'd0, spk1}, 32'd0);
                @(negedge clk);
                chk("first_rise", {31'd0, spk1}, 32'd1);
            end
            repeat (tbl[v].hold) @(negedge clk);
        end

        // Re-applying the same value must not disturb the phase.
        note   = 16'h0200;
        octave = 4'd4;
        repeat (400) @(negedge clk);
        chk("pre_reset_high", {31'd0, spk1}, 32'd1);

        // Asynchronous reset mid-tone.
        #2 rstn = 1'b0;
        #1;
        chk("async_rst_spk",     {31'd0, spk1},    32'd0);
        chk("async_rst_active",  {31'd0, active1}, 32'd0);
        chk("async_rst_spk4",    {31'd0, spk4},    32'd0);
        chk("async_rst_active4", {31'd0, active4}, 32'd0);
        repeat (3) @(negedge clk);
        rstn = 1'b1;
        @(negedge clk);
        chk("post_rst_active", {31'd0, active1}, 32'd1);
        chk("post_rst_low",    {31'd0, spk1},    32'd0);
        repeat (1135) @(negedge clk);
        chk("post_rst_pre_rise", {31'd0, spk1}, 32'd0);
        @(negedge clk);
        chk("post_rst_rise", {31'd0, spk1}, 32'd1);

        // Randomized segments checked by the model.
        for (int s = 0; s < 20; s++) begin
            if ($urandom_range(0, 9) < 7) begin
                note = 16'h0000;
                note[$urandom_range(0, 11)] = 1'b1;
            end else begin
                note = 16'($urandom);
            end
            octave = 4'($urandom_range(0, 10));
            repeat ($urandom_range(20, 400)) @(negedge clk);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
